// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing the shared-memory, shared-ULA multicycle MIPS datapath
// Ports: clk, reset (sync, active-high); OP/Funct from the instruction register;
// datapath controls IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, ULASrcA, ULASrcB,
// ULAControl, RegDst, MemtoReg, RegWrite; InstrDone pulses in each instruction's last state;
// State exposes the current state encoding.
module multicycle_control_unit #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] OP,
  input  logic [WIDTH-1:0] Funct,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic [1:0]       PCSrc,
  output logic             ULASrcA,
  output logic [1:0]       ULASrcB,
  output logic [2:0]       ULAControl,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             InstrDone,
  output logic [3:0]       State
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;
  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       ula_src_a;
    logic [1:0] ula_src_b;
    logic [2:0] ula_control;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
  } ctrl_t;
  localparam logic [WIDTH-1:0] OP_R    = WIDTH'(6'b000000);
  localparam logic [WIDTH-1:0] OP_LW   = WIDTH'(6'b100011);
  localparam logic [WIDTH-1:0] OP_SW   = WIDTH'(6'b101011);
  localparam logic [WIDTH-1:0] OP_BEQ  = WIDTH'(6'b000100);
  localparam logic [WIDTH-1:0] OP_ADDI = WIDTH'(6'b001000);
  localparam logic [WIDTH-1:0] OP_J    = WIDTH'(6'b000010);
  localparam logic [WIDTH-1:0] F_ADD   = WIDTH'(6'b100000);
  localparam logic [WIDTH-1:0] F_SUB   = WIDTH'(6'b100010);
  localparam logic [WIDTH-1:0] F_AND   = WIDTH'(6'b100100);
  localparam logic [WIDTH-1:0] F_OR    = WIDTH'(6'b100101);
  localparam logic [WIDTH-1:0] F_SLT   = WIDTH'(6'b101010);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [2:0]       alu_q, alu_d, alu_dec;
  logic             funct_ok;
  ctrl_t            ctrl_q, ctrl_d, ctrl;
  function automatic ctrl_t decode(input state_t s, input logic [2:0] alu);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.ula_src_b   = 2'b01;
        c.ula_control = 3'b010;
        c.ir_write    = 1'b1;
        c.pc_write    = 1'b1;
      end
      DECODE: begin
        c.ula_src_b   = 2'b11;
        c.ula_control = 3'b010;
      end
      MEMADR, ADDIEXEC: begin
        c.ula_src_a   = 1'b1;
        c.ula_src_b   = 2'b10;
        c.ula_control = 3'b010;
      end
      MEMRD: c.iord = 1'b1;
      MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      MEMWR: begin
        c.iord       = 1'b1;
        c.mem_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      EXECUTE: begin
        c.ula_src_a   = 1'b1;
        c.ula_control = alu;
      end
      ALUWB: begin
        c.reg_dst    = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      BRANCH: begin
        c.ula_src_a   = 1'b1;
        c.ula_control = 3'b110;
        c.pc_src      = 2'b01;
        c.branch      = 1'b1;
        c.instr_done  = 1'b1;
      end
      ADDIWB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      JUMP: begin
        c.pc_src     = 2'b10;
        c.pc_write   = 1'b1;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction
  always_comb begin
    alu_dec  = Funct == F_ADD ? 3'b010 :
               Funct == F_SUB ? 3'b110 :
               Funct == F_AND ? 3'b000 :
               Funct == F_OR  ? 3'b001 :
               Funct == F_SLT ? 3'b111 : 3'b000;
    funct_ok = Funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
  end
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE:   state_d = (OP == OP_LW || OP == OP_SW) ? MEMADR :
                          (OP == OP_R && funct_ok)     ? EXECUTE :
                          OP == OP_BEQ                 ? BRANCH :
                          OP == OP_ADDI                ? ADDIEXEC :
                          OP == OP_J                   ? JUMP : FETCH;
      MEMADR:   state_d = op_q == OP_SW ? MEMWR : MEMRD;
      MEMRD:    state_d = MEMWB;
      EXECUTE:  state_d = ALUWB;
      ADDIEXEC: state_d = ADDIWB;
      default:  state_d = FETCH;
    endcase
  end
  // OP and the Funct decode are captured while leaving DECODE so later states ignore the live inputs
  always_comb begin
    op_d   = state_q == DECODE ? OP : op_q;
    alu_d  = state_q == DECODE ? alu_dec : alu_q;
    ctrl_d = decode(state_d, alu_d);
  end
  // controls are registered from the next state, so they reflect the current state with no decode delay
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= '0;
      alu_q   <= '0;
      ctrl_q  <= decode(FETCH, 3'b000);
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      alu_q   <= alu_d;
      ctrl_q  <= ctrl_d;
    end
  end
  // reset forces every output low immediately, aborting any in-flight write
  assign ctrl       = reset ? '0 : ctrl_q;
  assign State      = reset ? 4'd0 : state_q;
  assign IorD       = ctrl.iord;
  assign MemWrite   = ctrl.mem_write;
  assign IRWrite    = ctrl.ir_write;
  assign PCWrite    = ctrl.pc_write;
  assign Branch     = ctrl.branch;
  assign PCSrc      = ctrl.pc_src;
  assign ULASrcA    = ctrl.ula_src_a;
  assign ULASrcB    = ctrl.ula_src_b;
  assign ULAControl = ctrl.ula_control;
  assign RegDst     = ctrl.reg_dst;
  assign MemtoReg   = ctrl.mem_to_reg;
  assign RegWrite   = ctrl.reg_write;
  assign InstrDone  = ctrl.instr_done;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: table-driven per-cycle check of the multicycle controller
module tb_multicycle_control_unit;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] OP = '0;
  logic [5:0] Funct = '0;
  logic       IorD, MemWrite, IRWrite, PCWrite, Branch, ULASrcA, RegDst, MemtoReg, RegWrite, InstrDone;
  logic [1:0] PCSrc, ULASrcB;
  logic [2:0] ULAControl;
  logic [3:0] State;
  int         checks = 0;
  int         passed = 0;
  multicycle_control_unit #(.WIDTH(6)) dut (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .PCSrc(PCSrc), .ULASrcA(ULASrcA), .ULASrcB(ULASrcB),
    .ULAControl(ULAControl), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .InstrDone(InstrDone), .State(State)
  );
  always #5 clk = ~clk;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;
  // {IorD,MemWrite,IRWrite,PCWrite,Branch,PCSrc,ULASrcA,ULASrcB,ULAControl,RegDst,MemtoReg,RegWrite,InstrDone}
  localparam logic [16:0] C_Z   = 17'b0_0_0_0_0_00_0_00_000_0_0_0_0;
  localparam logic [16:0] C_F   = 17'b0_0_1_1_0_00_0_01_010_0_0_0_0;
  localparam logic [16:0] C_D   = 17'b0_0_0_0_0_00_0_11_010_0_0_0_0;
  localparam logic [16:0] C_MA  = 17'b0_0_0_0_0_00_1_10_010_0_0_0_0;
  localparam logic [16:0] C_MR  = 17'b1_0_0_0_0_00_0_00_000_0_0_0_0;
  localparam logic [16:0] C_MWB = 17'b0_0_0_0_0_00_0_00_000_0_1_1_1;
  localparam logic [16:0] C_MWR = 17'b1_1_0_0_0_00_0_00_000_0_0_0_1;
  localparam logic [16:0] C_AWB = 17'b0_0_0_0_0_00_0_00_000_1_0_1_1;
  localparam logic [16:0] C_BR  = 17'b0_0_0_0_1_01_1_00_110_0_0_0_1;
  localparam logic [16:0] C_IWB = 17'b0_0_0_0_0_00_0_00_000_0_0_1_1;
  localparam logic [16:0] C_J   = 17'b0_0_0_1_0_10_0_00_000_0_0_0_1;
  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [3:0]  st;
    logic [16:0] ctrl;
  } vec_t;
  vec_t vq[$];
  function automatic vec_t v(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                             input logic [3:0] st, input logic [16:0] ctrl);
    vec_t r;
    r.rst = rst; r.op = op; r.fn = fn; r.st = st; r.ctrl = ctrl;
    return r;
  endfunction
  function automatic logic [16:0] c_ex(input logic [2:0] alu);
    return {5'b0, 2'b00, 1'b1, 2'b00, alu, 4'b0000};
  endfunction
  function automatic logic [16:0] outs();
    return {IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, ULASrcA, ULASrcB, ULAControl,
            RegDst, MemtoReg, RegWrite, InstrDone};
  endfunction
  task automatic check_vec(input int i, input vec_t e);
    checks++;
    if (State === e.st) passed++;
    else $display("FAIL vec %0d state: got %0d want %0d", i, State, e.st);
    checks++;
    if (outs() === e.ctrl) passed++;
    else $display("FAIL vec %0d ctrl: got %017b want %017b", i, outs(), e.ctrl);
    checks++;
    if ($countones({MemWrite, RegWrite, IRWrite}) <= 1) passed++;
    else $display("FAIL vec %0d write_excl: got %03b want at most one", i, {MemWrite, RegWrite, IRWrite});
  endtask
  task automatic measure(input logic [5:0] op, input logic [5:0] fn, input int want, input string nm);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    OP = op;
    Funct = fn;
    for (int c = 0; c < 12 && !done; c++) begin
      n++;
      #1;
      if (InstrDone) done = 1;
      else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    checks++;
    if (done && n == want) passed++;
    else $display("FAIL cpi %s: got %0d cycles (done=%0d) want %0d", nm, n, done, want);
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    logic [5:0] rf[5];
    logic [2:0] ra[5];
    rf = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    ra = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    for (int i = 0; i < 3; i++) vq.push_back(v(1, BAD, BAD, 4'd0, C_Z));
    vq.push_back(v(0, RT, RT, 4'd0, C_F));
    vq.push_back(v(0, LW, RT, 4'd1, C_D));
    vq.push_back(v(0, SW, RT, 4'd2, C_MA));
    vq.push_back(v(0, BAD, RT, 4'd3, C_MR));
    vq.push_back(v(0, BAD, RT, 4'd4, C_MWB));
    vq.push_back(v(0, RT, RT, 4'd0, C_F));
    vq.push_back(v(0, SW, RT, 4'd1, C_D));
    vq.push_back(v(0, LW, RT, 4'd2, C_MA));
    vq.push_back(v(0, LW, RT, 4'd5, C_MWR));
    for (int k = 0; k < 5; k++) begin
      vq.push_back(v(0, RT, RT, 4'd0, C_F));
      vq.push_back(v(0, RT, rf[k], 4'd1, C_D));
      vq.push_back(v(0, BEQ, F_SUB, 4'd6, c_ex(ra[k])));
      vq.push_back(v(0, BEQ, F_SUB, 4'd7, C_AWB));
    end
    vq.push_back(v(0, RT, RT, 4'd0, C_F));
    vq.push_back(v(0, BEQ, RT, 4'd1, C_D));
    vq.push_back(v(0, RT, RT, 4'd8, C_BR));
    vq.push_back(v(0, RT, RT, 4'd0, C_F));
    vq.push_back(v(0, JMP, RT, 4'd1, C_D));
    vq.push_back(v(0, RT, RT, 4'd11, C_J));
    vq.push_back(v(0, RT, RT, 4'd0, C_F));
    vq.push_back(v(0, ADDI, RT, 4'd1, C_D));
    vq.push_back(v(0, RT, RT, 4'd9, C_MA));
    vq.push_back(v(0, RT, RT, 4'd10, C_IWB));
    vq.push_back(v(0, RT, RT, 4'd0, C_F));
    vq.push_back(v(0, BAD, RT, 4'd1, C_D));
    vq.push_back(v(0, RT, RT, 4'd0, C_F));
    vq.push_back(v(0, RT, 6'b000000, 4'd1, C_D));
    vq.push_back(v(0, RT, RT, 4'd0, C_F));
    vq.push_back(v(0, RT, 6'b100001, 4'd1, C_D));
    vq.push_back(v(0, RT, RT, 4'd0, C_F));
    vq.push_back(v(0, LW, RT, 4'd1, C_D));
    vq.push_back(v(0, RT, RT, 4'd2, C_MA));
    vq.push_back(v(1, RT, RT, 4'd0, C_Z));
    vq.push_back(v(0, SW, RT, 4'd0, C_F));
    vq.push_back(v(0, BAD, RT, 4'd1, C_D));
    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst;
      OP = vq[i].op;
      Funct = vq[i].fn;
      #1;
      check_vec(i, vq[i]);
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b0;
    measure(LW, RT, 5, "lw");
    measure(SW, RT, 4, "sw");
    measure(RT, F_ADD, 4, "add");
    measure(ADDI, RT, 4, "addi");
    measure(BEQ, RT, 3, "beq");
    measure(JMP, RT, 3, "j");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
